// File: rtl/host_result_tx.sv
// host_result_tx: transmit side of the host pin interface.
// Captures one set of TPU result words and then drains it to the host one
// byte per transfer, least significant byte of word 0 first. Each transfer
// uses a valid/ack handshake.
module host_result_tx #(
    parameter int unsigned NUM_WORDS = 4,
    parameter int unsigned WORD_W    = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load,
    input  logic [NUM_WORDS*WORD_W-1:0]   result_data,
    input  logic                          rd_req,
    input  logic                          tx_ack,
    output logic [7:0]                    tx_data,
    output logic                          tx_valid,
    output logic                          tx_last,
    output logic                          full,
    output logic                          busy,
    output logic                          done,
    output logic                          overrun
);

    localparam int unsigned NUM_BYTES = NUM_WORDS * WORD_W / 8;
    localparam int unsigned BUF_W     = NUM_WORDS * WORD_W;
    localparam int unsigned IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   byte_idx;
    logic [BUF_W-1:0]   buffer;
    logic [IDX_W-1:0]   idx_nxt;
    logic [7:0]         next_byte;

    // Select the byte that follows the one currently on tx_data.
    always_comb begin
        idx_nxt   = byte_idx + IDX_W'(1);
        next_byte = '0;
        for (int unsigned k = 0; k < NUM_BYTES; k++) begin
            if (idx_nxt == IDX_W'(k)) begin
                next_byte = buffer[8*k +: 8];
            end
        end
    end

    // Capture/hold/send sequencer with all outputs registered.
    // tx_data and tx_last are loaded one cycle ahead, so the byte for
    // the next index is already on the pins when the current transfer completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            byte_idx <= '0;
            buffer   <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            tx_last  <= 1'b0;
            full     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        buffer <= result_data;
                        full   <= 1'b1;
                        state  <= HOLD;
                    end
                end
                HOLD: begin
                    if (load) begin
                        buffer <= result_data;
                    end else if (rd_req) begin
                        state    <= SEND;
                        byte_idx <= '0;
                        overrun  <= 1'b0;
                        busy     <= 1'b1;
                        tx_valid <= 1'b1;
                        tx_data  <= buffer[7:0];
                        tx_last  <= (NUM_BYTES == 1);
                    end
                end
                SEND: begin
                    if (load) begin
                        overrun <= 1'b1;
                    end
                    if (tx_ack) begin
                        if (byte_idx == LAST_IDX) begin
                            state    <= IDLE;
                            byte_idx <= '0;
                            tx_valid <= 1'b0;
                            tx_last  <= 1'b0;
                            tx_data  <= '0;
                            full     <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            byte_idx <= idx_nxt;
                            tx_data  <= next_byte;
                            tx_last  <= (idx_nxt == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_host_result_tx.sv
// Directed testbench for host_result_tx with hand-computed byte sequences.
module tb_host_result_tx;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [63:0] result_data;
    logic        rd_req;
    logic        tx_ack;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_last;
    logic        full;
    logic        busy;
    logic        done;
    logic        overrun;

    int total;
    int bad;

    // Word 3..0 = 8001, 0F0F, ABCD, 1234
    localparam logic [63:0] DATA_A = 64'h8001_0F0F_ABCD_1234;
    localparam logic [63:0] DATA_B = 64'h5566_7788_99AA_BBCC;
    localparam logic [63:0] DATA_F = 64'hFFFF_FFFF_FFFF_FFFF;

    logic [7:0] exp_a [8];
    logic [7:0] exp_b [8];

    host_result_tx #(
        .NUM_WORDS(4),
        .WORD_W(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .load(load),
        .result_data(result_data),
        .rd_req(rd_req),
        .tx_ack(tx_ack),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_last(tx_last),
        .full(full),
        .busy(busy),
        .done(done),
        .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data"},  32'(tx_data), 32'h0);
        chk({tag, "_valid"}, 32'(tx_valid), 32'h0);
        chk({tag, "_last"},  32'(tx_last), 32'h0);
        chk({tag, "_full"},  32'(full), 32'h0);
        chk({tag, "_busy"},  32'(busy), 32'h0);
        chk({tag, "_done"},  32'(done), 32'h0);
        chk({tag, "_ovr"},   32'(overrun), 32'h0);
    endtask

    // Load a buffer and issue a read; on return byte 0 is presented.
    task automatic load_and_read(input logic [63:0] d);
        load = 1'b1; result_data = d;
        tick();
        load = 1'b0;
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
    endtask

    // Continuous-ack drain of byte sequence e, then check the done pulse.
    task automatic drain(input string tag, input logic [7:0] e [8]);
        tx_ack = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk({tag, "_byte"},  32'(tx_data), 32'(e[k]));
            chk({tag, "_valid"}, 32'(tx_valid), 32'h1);
            chk({tag, "_last"},  32'(tx_last), (k == 7) ? 32'h1 : 32'h0);
            tick();
        end
        tx_ack = 1'b0;
        chk({tag, "_done"},  32'(done), 32'h1);
        chk({tag, "_full"},  32'(full), 32'h0);
        chk({tag, "_busy"},  32'(busy), 32'h0);
        chk({tag, "_vend"},  32'(tx_valid), 32'h0);
        chk({tag, "_dend"},  32'(tx_data), 32'h0);
        tick();
        chk({tag, "_done1"}, 32'(done), 32'h0);
    endtask

    initial begin
        int xfers;
        total = 0;
        bad   = 0;
        exp_a = '{8'h34, 8'h12, 8'hCD, 8'hAB, 8'h0F, 8'h0F, 8'h01, 8'h80};
        exp_b = '{8'hCC, 8'hBB, 8'hAA, 8'h99, 8'h88, 8'h77, 8'h66, 8'h55};

        rst_n = 1'b0; load = 1'b0; rd_req = 1'b0; tx_ack = 1'b0;
        result_data = '0;
        tick(); tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Basic drain
        load = 1'b1; result_data = DATA_A;
        tick();
        load = 1'b0;
        chk("hold_full",  32'(full), 32'h1);
        chk("hold_busy",  32'(busy), 32'h0);
        chk("hold_valid", 32'(tx_valid), 32'h0);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        chk("send_busy", 32'(busy), 32'h1);
        drain("basic", exp_a);

        // Stalled ack: each byte visible 4 cycles, ack on the 4th
        load_and_read(DATA_A);
        xfers = 0;
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 4; j++) begin
                tx_ack = (j == 3);
                chk("stall_byte",  32'(tx_data), 32'(exp_a[k]));
                chk("stall_valid", 32'(tx_valid), 32'h1);
                chk("stall_last",  32'(tx_last), (k == 7) ? 32'h1 : 32'h0);
                if (tx_valid && tx_ack) xfers++;
                tick();
            end
        end
        tx_ack = 1'b0;
        chk("stall_done", 32'(done), 32'h1);
        chk("stall_xfers", 32'(xfers), 32'd8);
        tick();

        // Overrun: load of all-ones at byte 2 is dropped
        load_and_read(DATA_A);
        tx_ack = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("ovr_byte", 32'(tx_data), 32'(exp_a[k]));
            if (k == 2) begin
                load = 1'b1; result_data = DATA_F;
            end
            tick();
            load = 1'b0;
            if (k >= 2 && k < 7) chk("ovr_flag_mid", 32'(overrun), 32'h1);
        end
        tx_ack = 1'b0;
        chk("ovr_done", 32'(done), 32'h1);
        chk("ovr_sticky", 32'(overrun), 32'h1);
        tick();
        load = 1'b1; result_data = DATA_A;
        tick();
        load = 1'b0;
        chk("ovr_hold", 32'(overrun), 32'h1);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        chk("ovr_clear", 32'(overrun), 32'h0);
        drain("ovr_redrain", exp_a);

        // Ignored requests in IDLE
        rd_req = 1'b1; tx_ack = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("idle_valid", 32'(tx_valid), 32'h0);
            chk("idle_full",  32'(full), 32'h0);
        end
        rd_req = 1'b0; tx_ack = 1'b0;

        // load + rd_req together in HOLD: load wins
        load = 1'b1; result_data = DATA_A;
        tick();
        result_data = DATA_B; rd_req = 1'b1;
        tick();
        load = 1'b0; rd_req = 1'b0;
        chk("both_full",  32'(full), 32'h1);
        chk("both_busy",  32'(busy), 32'h0);
        chk("both_valid", 32'(tx_valid), 32'h0);
        tick();
        chk("both_still", 32'(tx_valid), 32'h0);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        drain("newdata", exp_b);

        // Asynchronous reset while byte 5 is presented
        load_and_read(DATA_A);
        tx_ack = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        tx_ack = 1'b0;
        chk("pre_rst_byte", 32'(tx_data), 32'h0F);
        chk("pre_rst_valid", 32'(tx_valid), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        tick();
        rst_n = 1'b1;
        tick();
        rd_req = 1'b1; tx_ack = 1'b1;
        tick();
        rd_req = 1'b0;
        for (int j = 0; j < 3; j++) begin
            chk("post_rst_valid", 32'(tx_valid), 32'h0);
            chk("post_rst_full",  32'(full), 32'h0);
            tick();
        end
        tx_ack = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/host_result_tx.md
Name: host_result_tx

Overview:
- Transmit side of the host pin interface: streams TPU result words back to the host, one byte per transfer, on the dedicated output pins.
- Top level decodes the host read command (uio_in[7:5] = 3'b101) into rd_req. It wires tx_data to uo_out and tx_valid/tx_last to uio_out, and drives tx_ack from a host-driven uio_in bit.
- Results are captured in one shot from the unified buffer when a computation completes. They are then drained little-endian under a valid/ack handshake.

Parameters:
- NUM_WORDS, 4, number of result words per capture.
- WORD_W, 16, bits per result word. Must be a multiple of 8.
- NUM_BYTES, NUM_WORDS*WORD_W/8 (derived, localparam), bytes per transmission. Default 8.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- load  input  1  one-cycle pulse: capture result_data.
- result_data  input  NUM_WORDS*WORD_W  flattened results. Word 0 in the LSBs.
- rd_req  input  1  one-cycle pulse: host requests the buffered results.
- tx_ack  input  1  host accepts the current byte; sampled at posedge.
- tx_data  output  8  byte presented to host (uo_out).
- tx_valid  output  1  tx_data holds a valid byte.
- tx_last  output  1  the current byte is byte NUM_BYTES-1.
- full  output  1  the capture buffer holds unsent results.
- busy  output  1  transmission in progress.
- done  output  1  one-cycle pulse after the final byte is acknowledged.
- overrun  output  1  sticky: a load arrived during SEND and was dropped.

Behaviour:
- Reset (rst_n=0, asynchronous), all outputs 0:
  - state=IDLE, byte_idx=0, buffer cleared.
  - tx_data=0, tx_valid=0, tx_last=0, full=0, busy=0, done=0, overrun=0.
- States: IDLE, HOLD, SEND. Every output is registered.
- IDLE:
  - load: capture result_data, go to HOLD.
  - rd_req and tx_ack are ignored.
- HOLD (full=1):
  - load: overwrite the buffer, stay in HOLD. This takes priority over a simultaneous rd_req, which is dropped.
  - rd_req (no load): go to SEND, byte_idx=0. Clear overrun.
- SEND (full=1, busy=1, tx_valid=1):
  - tx_data = buffer byte byte_idx. Byte k = buffer[8k+7:8k], so word 0 low byte goes first.
  - tx_last = (byte_idx == NUM_BYTES-1).
  - A transfer occurs at a posedge where tx_valid and tx_ack are both 1.
    - If not last: byte_idx+1, and the next byte is visible in the following cycle.
    - If last: go to IDLE; tx_valid, tx_last, full and busy fall; done=1 for exactly one cycle; tx_data returns to 0.
  - tx_ack held high gives one byte per cycle. tx_ack low holds tx_data/tx_last stable indefinitely.
  - load in SEND: ignored, buffer unchanged, overrun set to 1.
  - rd_req in SEND: ignored.
- Latency:
  - rd_req sampled at edge N gives byte 0 with tx_valid=1 after edge N.
  - A full drain with continuous ack takes NUM_BYTES cycles. done is high in the cycle after the final ack edge.
- overrun clears only on reset or on a rd_req accepted in HOLD.
- Reset mid-SEND: transmission is aborted, buffer discarded, outputs as reset. After release the block is in IDLE; no partial resend.
- byte_idx has width clog2(NUM_BYTES). No wrap occurs because the last transfer always leaves SEND.

Test Plan:
- Basic drain:
  - Stimulus: load with words {0x8001, 0x0F0F, 0xABCD, 0x1234} (word 0 = 0x1234); then rd_req; tx_ack held 1.
  - Required: tx_data = 34,12,CD,AB,0F,0F,01,80 on 8 consecutive cycles. tx_last only on 80. done pulses 1 cycle afterwards; full=0.
- Stalled ack:
  - Stimulus: same data; tx_ack low 3 cycles after each byte.
  - Required: each byte held stable 4 cycles with tx_valid=1; order unchanged; exactly 8 transfers.
- Overrun:
  - Stimulus: during SEND at byte 2, load 0xFFFF in all words.
  - Required: remaining bytes still CD,AB,0F,0F,01,80; overrun=1 until the next accepted rd_req.
- Ignored requests:
  - Stimulus: rd_req and tx_ack in IDLE.
  - Required: tx_valid stays 0.
  - Stimulus: load and rd_req in the same cycle in HOLD.
  - Required: buffer holds the new data, state stays HOLD, busy=0.
- Reset mid-send:
  - Stimulus: assert rst_n=0 asynchronously at byte 5.
  - Required: all outputs 0 immediately; after release, rd_req gives no tx_valid until a new load.
